// File: rtl/sdram_pingpong_ctrl.sv
// Ping-pong frame buffer arbiter for an SDRAM frame store: hands alternate buffers
// to the write and read sides, dropping writes that would overrun an unread frame.
module sdram_pingpong_ctrl #(
    parameter logic [23:0] BUF0_BASE   = 24'h000000,
    parameter logic [23:0] BUF1_BASE   = 24'h400000,
    parameter logic [23:0] FRAME_LEN   = 24'h12C000,
    parameter int unsigned LOAD_CYCLES = 2
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        frame_write_done,
    input  logic        frame_read_done,
    output logic [23:0] wr_addr,
    output logic [23:0] wr_max_addr,
    output logic        wr_load,
    output logic [23:0] rd_addr,
    output logic [23:0] rd_max_addr,
    output logic        rd_load,
    output logic        wr_buf_sel,
    output logic        rd_buf_sel,
    output logic        rd_valid,
    output logic        frame_drop,
    output logic [7:0]  drop_cnt
);

    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES);

    typedef enum logic [1:0] {WAIT_INIT, INIT_LOAD, RUN} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  full_reg, full_next, full_mid;
    logic        wr_sel_reg, wr_sel_next;
    logic        rd_sel_reg, rd_sel_next;
    logic [3:0]  wr_cnt_reg, wr_cnt_next;
    logic [3:0]  rd_cnt_reg, rd_cnt_next;
    logic        drop_reg, drop_next;
    logic [7:0]  drop_cnt_reg, drop_cnt_next;
    logic [23:0] wr_addr_reg, wr_max_reg, rd_addr_reg, rd_max_reg;
    logic        rd_valid_reg;

    always_comb begin
        state_next    = state_reg;
        full_next     = full_reg;
        full_mid      = full_reg;
        wr_sel_next   = wr_sel_reg;
        rd_sel_next   = rd_sel_reg;
        wr_cnt_next   = (wr_cnt_reg != 4'd0) ? wr_cnt_reg - 4'd1 : 4'd0;
        rd_cnt_next   = (rd_cnt_reg != 4'd0) ? rd_cnt_reg - 4'd1 : 4'd0;
        drop_next     = 1'b0;
        drop_cnt_next = drop_cnt_reg;

        case (state_reg)
            WAIT_INIT: begin
                full_next   = 2'b00;
                wr_sel_next = 1'b0;
                rd_sel_next = 1'b0;
                if (sdram_init_done) begin
                    state_next  = INIT_LOAD;
                    wr_cnt_next = LOAD_INIT;
                    rd_cnt_next = LOAD_INIT;
                end
            end
            INIT_LOAD: begin
                // Leave on the last cycle of the init load pulse.
                if (wr_cnt_reg <= 4'd1) state_next = RUN;
            end
            RUN: begin
                if (!sdram_init_done) begin
                    state_next  = WAIT_INIT;
                    full_next   = 2'b00;
                    wr_sel_next = 1'b0;
                    rd_sel_next = 1'b0;
                    wr_cnt_next = 4'd0;
                    rd_cnt_next = 4'd0;
                end else begin
                    // Read clear is applied before the write decision sees the flags.
                    if (frame_read_done) begin
                        full_mid[rd_sel_reg] = 1'b0;
                        rd_sel_next          = ~rd_sel_reg;
                        rd_cnt_next          = LOAD_INIT;
                    end
                    if (frame_write_done) begin
                        if (!full_mid[~wr_sel_reg]) begin
                            full_mid[wr_sel_reg] = 1'b1;
                            wr_sel_next          = ~wr_sel_reg;
                        end else begin
                            drop_next = 1'b1;
                            if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
                        end
                        wr_cnt_next = LOAD_INIT;
                    end
                    full_next = full_mid;
                end
            end
            default: state_next = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_reg    <= WAIT_INIT;
            full_reg     <= 2'b00;
            wr_sel_reg   <= 1'b0;
            rd_sel_reg   <= 1'b0;
            wr_cnt_reg   <= 4'd0;
            rd_cnt_reg   <= 4'd0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= 8'd0;
            wr_addr_reg  <= BUF0_BASE;
            wr_max_reg   <= BUF0_BASE + FRAME_LEN;
            rd_addr_reg  <= BUF0_BASE;
            rd_max_reg   <= BUF0_BASE + FRAME_LEN;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            full_reg     <= full_next;
            wr_sel_reg   <= wr_sel_next;
            rd_sel_reg   <= rd_sel_next;
            wr_cnt_reg   <= wr_cnt_next;
            rd_cnt_reg   <= rd_cnt_next;
            drop_reg     <= drop_next;
            drop_cnt_reg <= drop_cnt_next;
            wr_addr_reg  <= wr_sel_next ? BUF1_BASE : BUF0_BASE;
            wr_max_reg   <= (wr_sel_next ? BUF1_BASE : BUF0_BASE) + FRAME_LEN;
            rd_addr_reg  <= rd_sel_next ? BUF1_BASE : BUF0_BASE;
            rd_max_reg   <= (rd_sel_next ? BUF1_BASE : BUF0_BASE) + FRAME_LEN;
            rd_valid_reg <= full_next[rd_sel_next];
        end
    end

    assign wr_addr     = wr_addr_reg;
    assign wr_max_addr = wr_max_reg;
    assign wr_load     = (wr_cnt_reg != 4'd0);
    assign rd_addr     = rd_addr_reg;
    assign rd_max_addr = rd_max_reg;
    assign rd_load     = (rd_cnt_reg != 4'd0);
    assign wr_buf_sel  = wr_sel_reg;
    assign rd_buf_sel  = rd_sel_reg;
    assign rd_valid    = rd_valid_reg;
    assign frame_drop  = drop_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_sdram_pingpong_ctrl.sv
// Scoreboard bench for sdram_pingpong_ctrl: a frame-level model predicts every
// cycle's outputs into a queue; a monitor compares them after each clock edge.
module tb_sdram_pingpong_ctrl;

    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'h400000;
    localparam logic [23:0] FL = 24'h12C000;
    localparam int          L  = 2;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        frame_write_done = 1'b0;
    logic        frame_read_done = 1'b0;
    logic [23:0] wr_addr, wr_max_addr, rd_addr, rd_max_addr;
    logic        wr_load, rd_load, wr_buf_sel, rd_buf_sel, rd_valid, frame_drop;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    sdram_pingpong_ctrl #(
        .BUF0_BASE(B0), .BUF1_BASE(B1), .FRAME_LEN(FL), .LOAD_CYCLES(L)
    ) dut (
        .clk_ref(clk_ref), .rst(rst), .sdram_init_done(sdram_init_done),
        .frame_write_done(frame_write_done), .frame_read_done(frame_read_done),
        .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .wr_load(wr_load),
        .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_load(rd_load),
        .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel), .rd_valid(rd_valid),
        .frame_drop(frame_drop), .drop_cnt(drop_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    // Model: 0 = waiting for init, 1 = init load, 2 = running.
    int       m_state = 0;
    bit [1:0] m_full = 2'b00;
    bit       m_ws = 1'b0, m_rs = 1'b0, m_drop = 1'b0;
    int       m_wl = 0, m_rl = 0, m_cnt = 0;

    logic [109:0] exp_q[$];

    task automatic model_step(input bit r, input bit i, input bit w, input bit rd);
        if (r) begin
            m_state = 0; m_full = 2'b00; m_ws = 0; m_rs = 0;
            m_drop = 0; m_wl = 0; m_rl = 0; m_cnt = 0;
            return;
        end
        m_drop = 0;
        if (m_wl > 0) m_wl--;
        if (m_rl > 0) m_rl--;
        case (m_state)
            0: begin
                m_full = 2'b00; m_ws = 0; m_rs = 0;
                if (i) begin m_state = 1; m_wl = L; m_rl = L; end
            end
            1: if (m_wl == 0) m_state = 2;
            default: begin
                if (!i) begin
                    m_state = 0; m_full = 2'b00; m_ws = 0; m_rs = 0; m_wl = 0; m_rl = 0;
                end else begin
                    if (rd) begin m_full[m_rs] = 0; m_rs = ~m_rs; m_rl = L; end
                    if (w) begin
                        if (!m_full[~m_ws]) begin m_full[m_ws] = 1; m_ws = ~m_ws; end
                        else begin m_drop = 1; if (m_cnt < 255) m_cnt++; end
                        m_wl = L;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [109:0] pack_exp();
        logic [23:0] wa, wm, ra, rm;
        logic [7:0]  c;
        wa = m_ws ? B1 : B0;
        wm = wa + FL;
        ra = m_rs ? B1 : B0;
        rm = ra + FL;
        c  = 8'(m_cnt);
        return {wa, wm, logic'(m_wl > 0), ra, rm, logic'(m_rl > 0),
                logic'(m_ws), logic'(m_rs), logic'(m_full[m_rs]), logic'(m_drop), c};
    endfunction

    task automatic cyc(input bit r, input bit i, input bit w, input bit rd);
        @(negedge clk_ref);
        rst = r; sdram_init_done = i; frame_write_done = w; frame_read_done = rd;
        model_step(r, i, w, rd);
        exp_q.push_back(pack_exp());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk_ref) begin
        logic [109:0] e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {wr_addr, wr_max_addr, wr_load, rd_addr, rd_max_addr, rd_load,
                 wr_buf_sel, rd_buf_sel, rd_valid, frame_drop, drop_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    initial begin
        repeat (3) cyc(1, 0, 0, 0);
        repeat (9) cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        @(negedge clk_ref);
        chk("init_wr_max", {8'd0, wr_max_addr}, 32'h0012C000);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        @(negedge clk_ref);
        chk("drop_once", {24'd0, drop_cnt}, 32'd1);
        cyc(0, 1, 1, 1);
        repeat (3) cyc(0, 1, 0, 0);
        @(negedge clk_ref);
        chk("simul_sels", {30'd0, rd_buf_sel, wr_buf_sel}, 32'b10);
        chk("simul_valid", {31'd0, rd_valid}, 32'd1);

        for (int n = 0; n < 600; n++)
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));

        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        repeat (300) cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        @(negedge clk_ref);
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        repeat (2) cyc(0, 0, 0, 0);
        @(negedge clk_ref);
        chk("deinit_valid", {31'd0, rd_valid}, 32'd0);
        chk("deinit_cnt", {24'd0, drop_cnt}, 32'd255);

        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        @(negedge clk_ref);
        chk("rst_midload", {31'd0, wr_load}, 32'd0);
        repeat (4) cyc(0, 0, 0, 0);

        @(posedge clk_ref);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_pingpong_ctrl.md
SDRAM_PINGPONG_CTRL -- requirements
Module: sdram_pingpong_ctrl

Interface
REQ-001 SHALL have parameter BUF0_BASE, default 24'h000000, start word address of frame buffer 0.
REQ-002 SHALL have parameter BUF1_BASE, default 24'h400000, start word address of frame buffer 1.
REQ-003 SHALL have parameter FRAME_LEN, default 24'h12C000, words per frame; max address = base + FRAME_LEN.
REQ-004 SHALL have parameter LOAD_CYCLES, default 2, width of every wr_load/rd_load pulse in clocks (1..15).
REQ-005 SHALL use one clock and a synchronous, active-high reset, exactly as decided.
REQ-006 clk_ref  in  1  SDRAM reference clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 sdram_init_done  in  1  SDRAM controller initialisation complete (level).
REQ-009 frame_write_done  in  1  one-clock pulse: the write side finished a frame.
REQ-010 frame_read_done  in  1  one-clock pulse: the read side finished a frame.
REQ-011 wr_addr, wr_max_addr  out  24 each  start and max write address of the current write buffer.
REQ-012 wr_load  out  1  write address reset pulse.
REQ-013 rd_addr, rd_max_addr  out  24 each  start and max read address of the current read buffer.
REQ-014 rd_load  out  1  read address reset pulse.
REQ-015 wr_buf_sel, rd_buf_sel  out  1 each  current write and read buffer index.
REQ-016 rd_valid  out  1  current read buffer holds a complete frame.
REQ-017 frame_drop  out  1  one-clock pulse: a written frame was discarded.
REQ-018 drop_cnt  out  8  count of discarded frames, saturating at 255.

Function
REQ-019 SHALL implement FSM WAIT_INIT -> INIT_LOAD -> RUN.
REQ-020 WAIT_INIT: full[1:0]=0, sel=0, no loads; leave when sdram_init_done=1.
REQ-021 INIT_LOAD: wr_load=rd_load=1 for exactly LOAD_CYCLES clocks, then RUN.
REQ-022 RUN: sdram_init_done=0 SHALL return to WAIT_INIT next clock, clear full, zero both sels and both load pulses; drop_cnt retained.
REQ-023 Frame pulses outside RUN SHALL be ignored.
REQ-024 Read event (RUN): clear full[rd_buf_sel], toggle rd_buf_sel, start rd_load pulse.
REQ-025 Write event (RUN): if full[~wr_buf_sel]=0 after any same-cycle read clear, set full[wr_buf_sel], toggle wr_buf_sel; otherwise leave full unchanged, keep wr_buf_sel, pulse frame_drop, increment drop_cnt (saturating). wr_load pulse starts in both cases.
REQ-026 Simultaneous read and write events SHALL apply the read clear first, then the write decision.
REQ-027 Latency: event on clock N -> updated sels, addresses, rd_valid, and first load cycle (high) on clock N+1; frame_drop high only on N+1.
REQ-028 A new event during an active load pulse SHALL restart that pulse's LOAD_CYCLES counter.
REQ-029 x_addr = x_buf_sel ? BUF1_BASE : BUF0_BASE; x_max_addr = x_addr + FRAME_LEN, modulo 2^24; both registered.
REQ-030 rd_valid = full[rd_buf_sel], registered.

Reset
REQ-031 rst SHALL force state WAIT_INIT, full=0, sels=0, wr_addr=rd_addr=BUF0_BASE, wr_max_addr=rd_max_addr=BUF0_BASE+FRAME_LEN, wr_load=rd_load=0, rd_valid=0, frame_drop=0, drop_cnt=0, load counters=0.
REQ-032 rst mid-pulse or mid-frame SHALL abort everything on the next edge with no residual load pulse.

Verification
REQ-033 Reset, init_done at clock 10 -> wr_load=rd_load=1 clocks 11-12, RUN from 13, addresses 000000/12C000.
REQ-034 write_done -> next clock wr_buf_sel=1, wr_addr=400000, wr_max_addr=52C000, wr_load 2 clocks, rd_valid=1.
REQ-035 Second write_done before any read_done -> frame_drop 1 clock, drop_cnt=1, wr_buf_sel stays 1, rd_valid stays 1.
REQ-036 read_done and write_done same clock with full=01, R=0, W=1 -> full=10, rd_buf_sel=1, wr_buf_sel=0, rd_valid=1, no drop.
REQ-037 300 forced drops -> drop_cnt holds 255; init_done deasserted in RUN -> WAIT_INIT, rd_valid=0, drop_cnt=255.
REQ-038 rst asserted in second wr_load cycle -> wr_load=0 next clock, all outputs at REQ-031 values.
